// File: rtl/blocking_port_arbiter_pkg.sv
// Shared types for blocking_port_arbiter: section encoding and a one-hot helper.
package blocking_port_arbiter_types;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    CAPT = 2'd1,
    SEND = 2'd2
  } BLOCKING_PORT_ARBITER_SECTIONS;

  // Widest requester vector the helper can encode; callers truncate to N.
  localparam int ONEHOT_W = 32;

  function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned idx);
    return {{(ONEHOT_W-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/blocking_port_arbiter_rr_picker.sv
// Combinational round-robin search: first requester after last_grant, wrapping N-1 -> 0.
module bpa_rr_picker #(
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] last_grant,
  output logic [SW-1:0] grant,
  output logic          any_req
);

  // Walk the candidates farthest-first so the nearest pending one wins.
  always_comb begin
    int idx;
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % N;
      if (req[idx]) begin
        grant   = SW'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/blocking_port_arbiter.sv
// Round-robin arbiter sharing one blocking output channel among N requesters.
// Define BLOCKING_PORT_ARBITER_LOCK_EN to add req_lock (grant re-use on the next word).
module blocking_port_arbiter
  import blocking_port_arbiter_types::*;
#(
  parameter  int N  = 4,
  parameter  int DW = 32,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N*DW-1:0] req_data,
  input  logic [N-1:0]  req_sync,
`ifdef BLOCKING_PORT_ARBITER_LOCK_EN
  input  logic [N-1:0]  req_lock,
`endif
  output logic [N-1:0]  req_notify,
  output logic [DW-1:0] out_data,
  output logic [SW-1:0] out_src,
  output logic          out_notify,
  input  logic          out_sync
);

  BLOCKING_PORT_ARBITER_SECTIONS section_q, section_d;
  logic [N-1:0]  req_notify_q, req_notify_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [SW-1:0] out_src_q, out_src_d;
  logic          out_notify_q, out_notify_d;
  logic [SW-1:0] last_grant_q, last_grant_d;
  logic [SW-1:0] grant_q, grant_d;

  logic [SW-1:0] pick_grant;
  logic          pick_any;
  logic [SW-1:0] arb_grant;
  logic          arb_any;

  bpa_rr_picker #(.N(N)) u_picker (
    .req        (req_sync),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .any_req    (pick_any)
  );

`ifdef BLOCKING_PORT_ARBITER_LOCK_EN
  logic lock_q, lock_d;
  logic lock_hit;

  // A locked requester that is still asking keeps the channel for its next word.
  assign lock_hit  = lock_q && req_sync[last_grant_q];
  assign arb_grant = lock_hit ? last_grant_q : pick_grant;
  assign arb_any   = lock_hit || pick_any;
`else
  assign arb_grant = pick_grant;
  assign arb_any   = pick_any;
`endif

  always_comb begin
    section_d    = section_q;
    req_notify_d = req_notify_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    out_notify_d = out_notify_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
`ifdef BLOCKING_PORT_ARBITER_LOCK_EN
    lock_d       = lock_q;
`endif
    case (section_q)
      ARB: begin
`ifdef BLOCKING_PORT_ARBITER_LOCK_EN
        lock_d = 1'b0;
`endif
        if (arb_any) begin
          grant_d      = arb_grant;
          req_notify_d = N'(onehot(32'(arb_grant)));
          section_d    = CAPT;
        end
      end
      CAPT: begin
        req_notify_d = '0;
        // A requester that withdrew loses its turn without moving the pointer.
        if (req_sync[grant_q]) begin
          out_data_d   = req_data[int'(grant_q)*DW +: DW];
          out_src_d    = grant_q;
          out_notify_d = 1'b1;
          last_grant_d = grant_q;
          section_d    = SEND;
`ifdef BLOCKING_PORT_ARBITER_LOCK_EN
          lock_d       = req_lock[grant_q];
`endif
        end else begin
          section_d = ARB;
        end
      end
      SEND: begin
        if (out_sync) begin
          out_notify_d = 1'b0;
          section_d    = ARB;
        end
      end
      default: begin
        req_notify_d = '0;
        out_notify_d = 1'b0;
        section_d    = ARB;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      section_q    <= ARB;
      req_notify_q <= '0;
      out_data_q   <= '0;
      out_src_q    <= '0;
      out_notify_q <= 1'b0;
      last_grant_q <= SW'(N-1);
      grant_q      <= '0;
`ifdef BLOCKING_PORT_ARBITER_LOCK_EN
      lock_q       <= 1'b0;
`endif
    end else begin
      section_q    <= section_d;
      req_notify_q <= req_notify_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      out_notify_q <= out_notify_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
`ifdef BLOCKING_PORT_ARBITER_LOCK_EN
      lock_q       <= lock_d;
`endif
    end
  end

  assign req_notify = req_notify_q;
  assign out_data   = out_data_q;
  assign out_src    = out_src_q;
  assign out_notify = out_notify_q;

endmodule

// File: tb/tb_blocking_port_arbiter.sv
// Scoreboard bench for blocking_port_arbiter (N=4, DW=32); lock test runs with BLOCKING_PORT_ARBITER_LOCK_EN.
module tb_blocking_port_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_sync;
  logic [N-1:0]    req_notify;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_src;
  logic            out_notify;
  logic            out_sync;
`ifdef BLOCKING_PORT_ARBITER_LOCK_EN
  logic [N-1:0]    req_lock;
`endif

  blocking_port_arbiter #(.N(N), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_data   (req_data),
    .req_sync   (req_sync),
`ifdef BLOCKING_PORT_ARBITER_LOCK_EN
    .req_lock   (req_lock),
`endif
    .req_notify (req_notify),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_notify (out_notify),
    .out_sync   (out_sync)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   stamp_q[$];
  exp_t mon_e;

  // Per-requester word tables replayed by the requester model.
  logic [31:0] tab_data [N][8];
  logic        tab_lock [N][8];
  int          head [N];
  int          tail [N];
  logic [N-1:0] hold_off;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic push_word(input int i, input logic [31:0] d, input logic lk);
    tab_data[i][tail[i]] = d;
    tab_lock[i][tail[i]] = lk;
    tail[i]++;
  endtask

  task automatic expect_word(input int i, input logic [31:0] d);
    exp_t e;
    e.src  = 2'(i);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic apply_reqs();
    for (int i = 0; i < N; i++) begin
      logic v;
      v = head[i] < tail[i];
      req_sync[i] = v && !hold_off[i];
      req_data[i*DW +: DW] = v ? tab_data[i][head[i]] : 32'h0;
`ifdef BLOCKING_PORT_ARBITER_LOCK_EN
      req_lock[i] = v ? tab_lock[i][head[i]] : 1'b0;
`endif
    end
  endtask

  // One clock: note accepted words before the edge, then present the next ones.
  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = req_notify & req_sync;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i] && head[i] < tail[i]) head[i]++;
    apply_reqs();
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk(nm, 64'(exp_q.size()), 64'd0);
    tick();
    tick();
  endtask

  // Output-side monitor: pops the scoreboard on every consumer transfer.
  always @(negedge clk) begin
    if (!rst && out_notify && out_sync) begin
      stamp_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got src=%0d data=%h required none", out_src, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        $display("xfer cyc=%0d src=%0d data=%h (expect src=%0d data=%h)",
                 cyc, out_src, out_data, mon_e.src, mon_e.data);
        chk("out_src", 64'(out_src), 64'(mon_e.src));
        chk("out_data", 64'(out_data), 64'(mon_e.data));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    out_sync = 1'b1;
    req_sync = '0;
    req_data = '0;
    hold_off = '0;
`ifdef BLOCKING_PORT_ARBITER_LOCK_EN
    req_lock = '0;
`endif
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_notify", 64'(out_notify), 64'd0);
    chk("rst_req_notify", 64'(req_notify), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_src", 64'(out_src), 64'd0);
    rst = 1'b0;
    tick();

    // Fairness: all four pending, order 0,1,2,3,0,1, one word every 3 cycles.
    push_word(0, 32'hF000_0000, 1'b0);
    push_word(1, 32'hF000_0001, 1'b0);
    push_word(2, 32'hF000_0002, 1'b0);
    push_word(3, 32'hF000_0003, 1'b0);
    push_word(0, 32'hF000_0004, 1'b0);
    push_word(1, 32'hF000_0005, 1'b0);
    expect_word(0, 32'hF000_0000);
    expect_word(1, 32'hF000_0001);
    expect_word(2, 32'hF000_0002);
    expect_word(3, 32'hF000_0003);
    expect_word(0, 32'hF000_0004);
    expect_word(1, 32'hF000_0005);
    stamp_q.delete();
    apply_reqs();
    drain("fair_drain");
    chk("fair_count", 64'(stamp_q.size()), 64'd6);
    if (stamp_q.size() == 6)
      for (int k = 1; k < 6; k++)
        chk("fair_spacing", 64'(stamp_q[k] - stamp_q[k-1]), 64'd3);

    // Single requester latency: notify at T+1, word at T+2, done at T+3.
    push_word(2, 32'h0000_0055, 1'b0);
    expect_word(2, 32'h0000_0055);
    apply_reqs();
    tick();
    chk("single_req_notify", 64'(req_notify), 64'b0100);
    chk("single_early_notify", 64'(out_notify), 64'd0);
    tick();
    chk("single_out_notify", 64'(out_notify), 64'd1);
    chk("single_out_data", 64'(out_data), 64'h55);
    chk("single_out_src", 64'(out_src), 64'd2);
    chk("single_req_notify_clr", 64'(req_notify), 64'd0);
    tick();
    chk("single_out_notify_fall", 64'(out_notify), 64'd0);
    drain("single_drain");

    // Backpressure: output held while the consumer stalls; a new requester waits.
    out_sync = 1'b0;
    push_word(0, 32'h0000_00B0, 1'b0);
    expect_word(0, 32'h0000_00B0);
    expect_word(3, 32'h0000_00B3);
    apply_reqs();
    tick();
    chk("bp_req_notify", 64'(req_notify), 64'b0001);
    tick();
    chk("bp_out_notify_rise", 64'(out_notify), 64'd1);
    push_word(3, 32'h0000_00B3, 1'b0);
    apply_reqs();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_out_notify_hold", 64'(out_notify), 64'd1);
      chk("bp_out_data_hold", 64'(out_data), 64'hB0);
      chk("bp_out_src_hold", 64'(out_src), 64'd0);
      chk("bp_req_notify_idle", 64'(req_notify), 64'd0);
    end
    out_sync = 1'b1;
    tick();
    chk("bp_out_notify_fall", 64'(out_notify), 64'd0);
    drain("bp_drain");

    // Withdraw in CAPT: no word, pointer unchanged, requester 1 wins over 3 next.
    push_word(1, 32'h0000_00A1, 1'b0);
    expect_word(1, 32'h0000_00A1);
    expect_word(3, 32'h0000_00A3);
    apply_reqs();
    tick();
    chk("wd_req_notify", 64'(req_notify), 64'b0010);
    hold_off[1] = 1'b1;
    apply_reqs();
    tick();
    chk("wd_no_out_notify", 64'(out_notify), 64'd0);
    chk("wd_req_notify_clr", 64'(req_notify), 64'd0);
    hold_off[1] = 1'b0;
    push_word(3, 32'h0000_00A3, 1'b0);
    apply_reqs();
    tick();
    chk("wd_regrant", 64'(req_notify), 64'b0010);
    drain("wd_drain");

    // Reset during SEND discards the word and restores requester-0 priority.
    out_sync = 1'b0;
    push_word(2, 32'h0000_00C2, 1'b0);
    apply_reqs();
    tick();
    tick();
    chk("mid_send_out_notify", 64'(out_notify), 64'd1);
    #2;
    rst = 1'b1;
    for (int i = 0; i < N; i++) head[i] = tail[i];
    apply_reqs();
    tick();
    chk("mrst_out_notify", 64'(out_notify), 64'd0);
    chk("mrst_req_notify", 64'(req_notify), 64'd0);
    chk("mrst_out_data", 64'(out_data), 64'd0);
    chk("mrst_out_src", 64'(out_src), 64'd0);
    rst = 1'b0;
    out_sync = 1'b1;
    push_word(2, 32'h0000_00D2, 1'b0);
    push_word(0, 32'h0000_00D0, 1'b0);
    expect_word(0, 32'h0000_00D0);
    expect_word(2, 32'h0000_00D2);
    apply_reqs();
    drain("post_rst_drain");

`ifdef BLOCKING_PORT_ARBITER_LOCK_EN
    // Lock: requester 0 keeps the grant for one extra word, then 1 is served.
    push_word(0, 32'h0000_00E0, 1'b1);
    push_word(0, 32'h0000_00E1, 1'b0);
    push_word(1, 32'h0000_00E2, 1'b0);
    expect_word(0, 32'h0000_00E0);
    expect_word(0, 32'h0000_00E1);
    expect_word(1, 32'h0000_00E2);
    apply_reqs();
    drain("lock_drain");
`endif

    tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blocking_port_arbiter.md
Name: blocking_port_arbiter

Overview:
- Round-robin arbiter that shares one blocking output channel (data + sync/notify handshake) among N requester channels of the same protocol.
- Sits between several producer modules and a single consumer input port. Example: N writers feeding one b_in-style port.
- Sequenced by a section state machine. All handshake outputs are registered.
- Forwards each accepted word unchanged and tags it with its source index.

Parameters:
- N, 4: number of requesters; minimum 2.
- DW, 32: data width in bits.
- SW, $clog2(N): source tag width (derived; not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_data  in  N*DW  requester data; slice i = bits [i*DW +: DW]
- req_sync  in  N  requester i holds valid data
- req_notify  out  N  registered one-hot accept to requester i
- out_data  out  DW  forwarded word
- out_src  out  SW  index of the requester that produced out_data
- out_notify  out  1  out_data valid toward consumer
- out_sync  in  1  consumer ready

Behaviour:
- Handshake rule: a transfer occurs on a channel in any cycle where sync and notify are both 1. A requester holds data and sync stable until it transfers.
- Reset (async, all registers): section=ARB, req_notify=0, out_notify=0, out_data=0, out_src=0, last_grant=N-1 (requester 0 has top priority after reset).
- Reset mid-operation discards any captured or in-flight word. No partial transfer is visible after reset.
- ARB state:
  - If any req_sync bit is 1: g = first index with req_sync set, searching last_grant+1, last_grant+2, ... modulo N.
  - Then req_notify <= onehot(g), section <= CAPT.
  - Otherwise stay in ARB with all outputs at 0.
- CAPT state, if req_sync[g]=1 (transfer this cycle):
  - out_data <= slice g; out_src <= g; out_notify <= 1; last_grant <= g; section <= SEND.
- CAPT state, if req_sync[g]=0 (requester withdrew; protocol violation tolerated):
  - No transfer; last_grant unchanged; section <= ARB.
- CAPT state, both cases: req_notify <= 0.
- SEND state:
  - out_notify=1; out_data and out_src held stable.
  - When out_sync=1: out_notify <= 0, section <= ARB.
  - While out_sync=0: hold indefinitely. All req_notify stay 0.
- Throughput: minimum 3 cycles per word (ARB, CAPT, SEND). Latency from req_sync to out_notify is 2 cycles with out_sync held 1.
- Simultaneous requests are resolved only by the round-robin order. New req_sync edges during CAPT/SEND are ignored until the next ARB.
- Index wrap: the search wraps N-1 -> 0. For non-power-of-2 N, out_src never exceeds N-1.

Optional Feature:
- Macro: BLOCKING_PORT_ARBITER_LOCK_EN
- With macro: adds input req_lock (N bits).
  - If req_lock[g]=1 in the CAPT cycle that transfers, a lock flag is set.
  - In the next ARB, if lock is set and req_sync[g]=1, g is granted again, bypassing round-robin.
  - Otherwise lock clears and normal round-robin applies.
  - lock resets to 0.
- Without macro: req_lock port and lock flag do not exist; pure round-robin.

Decomposition:
- Shared package blocking_port_arbiter_types:
  - enum BLOCKING_PORT_ARBITER_SECTIONS {ARB, CAPT, SEND}
  - onehot helper function
- Sub-module bpa_rr_picker (combinational):
  - Inputs: req vector, last_grant.
  - Outputs: grant index, any_req.
  - Isolates the modulo search from the state machine.

Test Plan (N=4, DW=32):
- Reset: assert rst mid-SEND -> next cycle out_notify=0, req_notify=0000, out_data=0, out_src=0, section=ARB.
- Single requester: req_sync[2]=1 with 0x0000_0055 at cycle T, out_sync=1 -> req_notify=0100 at T+1; out_notify=1, out_data=0x55, out_src=2 at T+2; out_notify=0 at T+3.
- Fairness: all four req_sync held 1, out_sync=1 -> grant order 0,1,2,3,0,1. Each source served once per 12 cycles.
- Backpressure: out_sync=0 for 5 cycles after out_notify rises -> out_notify stays 1, out_data/out_src unchanged, req_notify=0000 throughout. One cycle after out_sync=1, out_notify=0.
- Withdraw: requester 1 granted, drops req_sync in CAPT -> no out_notify; last_grant unchanged. With requesters 1 and 3 pending next, 1 is granted again.
- Lock (macro on): requester 0 with req_lock=1, requester 1 also pending -> 0 granted twice in a row. With req_lock=0 on the second word -> 1 granted next.
